// File: rtl/nios_pio_pkg.sv
// Shared constants for the Nios PIO slaves: register offsets and edge-capture modes.
package nios_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/nios_bus_sync.sv
// WIDTH x SYNC_STAGES flop-chain synchroniser for an asynchronous bus; q is the last stage.
module nios_bus_sync #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/nios_result_pio_in.sv
// Avalon-MM input PIO: synchronised status bus, per-bit edge capture (W1C), irq mask, one irq.
module nios_result_pio_in
  import nios_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned IRQ_LEVEL   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] wdata;
  logic             wr;
  logic             unused_wdata;

  nios_bus_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (sync_out)
  );

  assign wr           = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_det = sync_out & ~prev;
      EDGE_FALL: edge_det = ~sync_out & prev;
      default:   edge_det = sync_out ^ prev;
    endcase
  end

  // A detected edge overrides a same-cycle software clear of that bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev         <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      prev <= sync_out;
      if (wr && address == ADDR_MASK) irq_mask <= wdata;
      if (wr && address == ADDR_EDGE) edge_capture <= (edge_capture & ~wdata) | edge_det;
      else                            edge_capture <= edge_capture | edge_det;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata = 32'(sync_out);
      ADDR_MASK: readdata = 32'(irq_mask);
      ADDR_EDGE: readdata = 32'(edge_capture);
      default:   readdata = '0;
    endcase
  end

  assign irq = (IRQ_LEVEL == 1) ? |(sync_out & irq_mask) : |(edge_capture & irq_mask);

endmodule

// File: doc/nios_result_pio_in.md
Name: nios_result_pio_in

Overview:
- Avalon-MM slave input port on the Nios system bus; the read-side counterpart of the 8-bit output PIO slaves.
- Synchronises a WIDTH-bit status/result bus from the recognition pipeline into the clk domain.
- Per-bit edge-capture register with write-1-to-clear and a per-bit interrupt mask.
- Drives one interrupt line to the Nios interrupt controller.

Parameters:
- WIDTH, 8: width of in_port and of every port register (1..32).
- SYNC_STAGES, 2: depth of the input synchroniser (2..4).
- EDGE_TYPE, 0: capture condition. 0 = rising, 1 = falling, 2 = any edge.
- IRQ_LEVEL, 0: interrupt source. 0 = from edge-capture register, 1 = from synchronised level.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data. Bits above WIDTH are ignored.
- in_port  in  WIDTH  asynchronous external status bus.
- readdata  out  32  read data, zero-extended above WIDTH.
- irq  out  1  active-high interrupt.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Every flop resets asynchronously to 0 while reset_n = 0. This covers synchroniser stages, previous-sample register, irq_mask and edge_capture.
- Register map (0 wait states; readdata is a combinational function of address and register state; chipselect is not required for reads):
  - addr 0 data: read-only, returns sync_out. Writes are ignored.
  - addr 1 reserved: reads 0. Writes are ignored.
  - addr 2 irq_mask: read/write. Loads writedata[WIDTH-1:0] on a write.
  - addr 3 edge_capture: read. A write with writedata bit i = 1 clears bit i. Bits written 0 are unchanged.
- A write is chipselect=1 and write_n=0 at a rising clk edge.
- Synchroniser:
  - in_port passes through a SYNC_STAGES-deep flop chain; the last stage is sync_out.
  - A change on in_port that is stable before edge 1 is visible at addr 0 after edge SYNC_STAGES.
- Edge detect:
  - prev <= sync_out every cycle.
  - Rising edge on bit i: sync_out[i] & ~prev[i].
  - Falling edge on bit i: ~sync_out[i] & prev[i].
  - Any edge: XOR of sync_out[i] and prev[i].
- Edge capture:
  - edge_capture[i] sets at the edge following detection, i.e. edge SYNC_STAGES+1 after the input change (edge 3 with defaults).
  - A bit stays set until software clears it.
  - If an edge is detected and a clear of the same bit occur in the same cycle, set wins and the bit stays 1.
- irq is combinational from registers:
  - IRQ_LEVEL=0: irq = |(edge_capture & irq_mask).
  - IRQ_LEVEL=1: irq = |(sync_out & irq_mask).
- Glitches shorter than one clk period may be missed; this is accepted.
- Reset boundary: reset clears prev and the synchroniser.
  - If in_port is held 1 through reset, the sync chain fills with 1 after release.
  - With EDGE_TYPE 0 or 2 this records a rising edge on cycle SYNC_STAGES+1 after reset release. This is required behaviour.
- Reset asserted mid-operation discards pending captures and the mask; irq drops to 0 immediately (asynchronously).

Decomposition:
- Shared package nios_pio_pkg holds:
  - Register offset constants: ADDR_DATA=0, ADDR_RSVD=1, ADDR_MASK=2, ADDR_EDGE=3.
  - EDGE_TYPE encodings: EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- One natural sub-module, nios_bus_sync: a parameterised WIDTH x SYNC_STAGES synchroniser with asynchronous active-low reset, reusable by other input PIOs.
- Edge detect, capture and bus decode stay in the top level.

Test Plan (defaults unless stated):
- Rising-edge capture and interrupt:
  - Stimulus: write mask=0x01; drive in_port 0x00 to 0x01 before edge 1.
  - Response: addr 0 reads 0x01 after edge 2; edge_capture=0x01 and irq=1 after edge 3.
  - Then write addr 3 = 0x01; irq=0 the following cycle.
- Set/clear collision:
  - Stimulus: pulse in_port[3] so its detect cycle coincides with a write of 0x08 to addr 3.
  - Response: edge_capture[3] stays 1; a clear one cycle later reads 0x00.
- Masking and per-bit clear:
  - Stimulus: mask=0x00; toggle in_port bits 0 and 7 low to high.
  - Response: edge_capture=0x81 and irq stays 0.
  - Then write mask=0x80; irq=1 on the next cycle.
  - Then write 0x01 to addr 3; reads 0x80 and irq stays 1.
- Reserved and read-only writes:
  - Stimulus: write 0xFFFFFFFF to addr 0 and addr 1.
  - Response: no state change; addr 1 reads 0; readdata[31:8] = 0 on every read.
- Reset cases:
  - Stimulus: in_port=0xFF held through reset, default EDGE_TYPE.
  - Response: after release, edge_capture=0xFF at cycle 3.
  - Stimulus: reset_n asserted mid-run with edge_capture=0x55 and mask=0xFF.
  - Response: irq=0 immediately; all registers read 0 after release.
- Variants:
  - EDGE_TYPE=1: only falling transitions capture; 0x01 to 0x00 gives edge_capture=0x01.
  - IRQ_LEVEL=1: irq follows sync_out & mask with SYNC_STAGES latency; edge_capture is unaffected.
